// File: rtl/am_eval_pkg.sv
// Shared types and sizing helpers for the approximate-multiplier
// error sweep.
package am_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  localparam int DRAIN_LEN = 2;

  function automatic int n_pairs(input int w);
    return 1 << (2 * w);
  endfunction

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int diff_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/am_err_accum.sv
// Stage 2: signed/absolute error formation and the four running
// error metrics.
module am_err_accum
  import am_eval_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   valid,
  input  logic [2*W-1:0]         approx,
  input  logic [2*W-1:0]         exact,
  output logic [cnt_w(W)-1:0]    err_cnt,
  output logic [ACC_W-1:0]       sum_abs_err,
  output logic [2*W-1:0]         max_abs_err,
  output logic [ACC_W:0]         sum_err
);

  localparam int DW = diff_w(W);
  localparam int CW = cnt_w(W);

  logic [DW-1:0]  diff;
  logic [DW-1:0]  neg;
  logic [2*W-1:0] mag;

  always_comb begin
    diff = {1'b0, approx} - {1'b0, exact};
    neg  = -diff;
    mag  = diff[DW-1] ? neg[2*W-1:0] : diff[2*W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      sum_err     <= '0;
    end else if (clear) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      sum_err     <= '0;
    end else if (valid) begin
      err_cnt     <= err_cnt + {{(CW-1){1'b0}}, |diff};
      sum_abs_err <= sum_abs_err + {{(ACC_W-2*W){1'b0}}, mag};
      if (mag > max_abs_err)
        max_abs_err <= mag;
      // diff is signed; widen by sign extension
      sum_err <= sum_err + {{(ACC_W+1-DW){diff[DW-1]}}, diff};
    end
  end

endmodule

// File: rtl/am_error_sweep.sv
// Exhaustive operand sweep for an attached approximate multiplier,
// with a registered capture stage feeding the error accumulators.
module am_error_sweep
  import am_eval_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [W-1:0]        op_x,
  output logic [W-1:0]        op_y,
  input  logic [2*W-1:0]      approx_z,
  output logic                busy,
  output logic                done,
  output logic [2*W:0]        err_cnt,
  output logic [ACC_W-1:0]    sum_abs_err,
  output logic [2*W-1:0]      max_abs_err,
  output logic [ACC_W:0]      sum_err
);

  localparam int DCW = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  state_t         state;
  logic [DCW-1:0] dcnt;
  logic           v1;
  logic [2*W-1:0] z1;
  logic [2*W-1:0] p1;
  logic [2*W-1:0] pair_nxt;
  logic           last;
  logic           go;
  logic           kill;

  assign pair_nxt = {op_x, op_y} + {{(2*W-1){1'b0}}, 1'b1};
  assign last     = &{op_x, op_y};
  assign go       = start && (state == IDLE || state == DONE);
  assign kill     = abort && (state == SWEEP || state == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
      op_x  <= '0;
      op_y  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      v1    <= 1'b0;
      z1    <= '0;
      p1    <= '0;
    end else begin
      v1 <= (state == SWEEP) && !abort;
      z1 <= approx_z;
      p1 <= {{W{1'b0}}, op_x} * {{W{1'b0}}, op_y};
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= SWEEP;
            op_x  <= '0;
            op_y  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        SWEEP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            {op_x, op_y} <= pair_nxt;
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (dcnt == DCW'(DRAIN_LEN - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  am_err_accum #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (go),
    .valid       (v1 && !kill),
    .approx      (z1),
    .exact       (p1),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err),
    .sum_err     (sum_err)
  );

endmodule

// File: tb/tb_am_error_sweep.sv
// Bench for am_error_sweep: W=8 LSB-drop sweep plus W=2 directed and
// randomized sweeps against a pair-by-pair reference model.
module tb_am_error_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start8, abort8, start2, abort2;

  logic [7:0]  x8, y8;
  logic [15:0] z8;
  logic        busy8, done8;
  logic [16:0] ec8;
  logic [39:0] sa8;
  logic [15:0] mx8;
  logic [40:0] se8;

  logic [1:0]  x2, y2;
  logic [3:0]  z2;
  logic        busy2, done2;
  logic [4:0]  ec2;
  logic [39:0] sa2;
  logic [3:0]  mx2;
  logic [40:0] se2;

  int          mode;
  logic [3:0]  tbl [16];

  int total = 0;
  int fails = 0;

  assign z8 = ({8'b0, x8} * {8'b0, y8}) & ~16'd1;

  always_comb begin
    z2 = '0;
    case (mode)
      0:       z2 = {2'b0, x2} * {2'b0, y2};
      1:       z2 = '0;
      default: z2 = tbl[{x2, y2}];
    endcase
  end

  am_error_sweep #(.W(8), .ACC_W(40)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .op_x(x8), .op_y(y8), .approx_z(z8),
    .busy(busy8), .done(done8), .err_cnt(ec8),
    .sum_abs_err(sa8), .max_abs_err(mx8), .sum_err(se8)
  );

  am_error_sweep #(.W(2), .ACC_W(40)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .op_x(x2), .op_y(y2), .approx_z(z2),
    .busy(busy2), .done(done2), .err_cnt(ec2),
    .sum_abs_err(sa2), .max_abs_err(mx2), .sum_err(se2)
  );

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exact product vs stub result for every W=2 pair, plain arithmetic.
  task automatic model2(output longint ec, output longint sa,
                        output longint mx, output longint se);
    longint ex, ap, d, a;
    ec = 0; sa = 0; mx = 0; se = 0;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        ex = x * y;
        if (mode == 0)      ap = ex;
        else if (mode == 1) ap = 0;
        else                ap = tbl[x*4+y];
        d = ap - ex;
        a = (d < 0) ? -d : d;
        if (d != 0) ec++;
        sa += a;
        if (a > mx) mx = a;
        se += d;
      end
    end
  endtask

  task automatic metrics2(input string tag);
    longint ec, sa, mx, se;
    model2(ec, sa, mx, se);
    check({tag, "_err_cnt"}, longint'(ec2), ec);
    check({tag, "_sum_abs"}, longint'(sa2), sa);
    check({tag, "_max_abs"}, longint'(mx2), mx);
    check({tag, "_sum_err"}, longint'($signed(se2)), se);
  endtask

  // Advance from cycle c0 until done, bounded; checks done cycle and
  // last busy cycle.
  task automatic wait_done(input bit wide, input int c0,
                           input int n, input string tag);
    int c, lb, lim;
    c = c0;
    lb = -1;
    lim = n + 50;
    check({tag, "_busy_on"}, longint'(wide ? busy8 : busy2), 1);
    while (!(wide ? done8 : done2) && c < lim) begin
      if (wide ? busy8 : busy2) lb = c;
      tick();
      c++;
    end
    check({tag, "_done_cycle"}, c, n + 3);
    check({tag, "_last_busy"}, lb, n + 2);
  endtask

  task automatic pulse_start2();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

  task automatic fill_tbl();
    for (int i = 0; i < 16; i++) tbl[i] = 4'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    mode = 0;
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tick();
    tick();
    check("rst_busy", longint'(busy2), 0);
    check("rst_done", longint'(done2), 0);
    check("rst_err_cnt", longint'(ec2), 0);
    check("rst_sum_abs", longint'(sa2), 0);
    check("rst_max_abs", longint'(mx2), 0);
    check("rst_sum_err", longint'(se2), 0);
    check("rst_op", longint'({x2, y2}), 0);
    check("rst_busy8", longint'(busy8), 0);
    rst_n = 1'b1;
    tick();

    // W=8 LSB-drop stub, full timing
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, 1, 65536, "w8");
    check("w8_err_cnt", longint'(ec8), 16384);
    check("w8_sum_abs", longint'(sa8), 16384);
    check("w8_max_abs", longint'(mx8), 1);
    check("w8_sum_err", longint'($signed(se8)), -16384);

    // W=2 zero stub
    mode = 1;
    pulse_start2();
    wait_done(1'b0, 1, 16, "zero");
    check("zero_err_cnt_const", longint'(ec2), 9);
    check("zero_sum_err_const", longint'($signed(se2)), -36);
    metrics2("zero");

    // start in DONE clears and restarts; start at cycle 5 ignored
    mode = 0;
    pulse_start2();
    check("restart_done_drop", longint'(done2), 0);
    check("restart_clear", longint'(ec2), 0);
    check("restart_busy", longint'(busy2), 1);
    for (int i = 0; i < 4; i++) tick();
    pulse_start2();
    wait_done(1'b0, 6, 16, "exact_ign");
    metrics2("exact");

    // randomized stubs
    for (int r = 0; r < 3; r++) begin
      fill_tbl();
      mode = 2;
      pulse_start2();
      wait_done(1'b0, 1, 16, $sformatf("rnd%0d", r));
      metrics2($sformatf("rnd%0d", r));
    end

    // abort at cycle 6
    mode = 1;
    pulse_start2();
    for (int i = 0; i < 5; i++) tick();
    abort2 = 1'b1;
    tick();
    abort2 = 1'b0;
    check("abort_busy", longint'(busy2), 0);
    check("abort_done", longint'(done2), 0);
    for (int i = 0; i < 20; i++) tick();
    check("abort_done_hold", longint'(done2), 0);
    pulse_start2();
    wait_done(1'b0, 1, 16, "post_abort");
    check("post_abort_err_cnt", longint'(ec2), 9);

    // asynchronous reset at cycle 8
    fill_tbl();
    mode = 2;
    pulse_start2();
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", longint'(busy2), 0);
    check("arst_done", longint'(done2), 0);
    check("arst_err_cnt", longint'(ec2), 0);
    check("arst_sum_abs", longint'(sa2), 0);
    check("arst_max_abs", longint'(mx2), 0);
    check("arst_sum_err", longint'(se2), 0);
    check("arst_op", longint'({x2, y2}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start2();
    wait_done(1'b0, 1, 16, "post_rst");
    metrics2("post_rst");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/am_error_sweep.md
Name: am_error_sweep

Overview:
- Sequencer and error-metric engine for the 8x8 unsigned approximate multipliers.
- Drives every operand pair (x, y) into an external approximate multiplier and reads back the approximate product.
- Compares each approximate product against the exact product it computes itself.
- Accumulates error count, sum of absolute error, maximum absolute error and signed error bias.
- Used in the evaluation harness. One instance per multiplier variant; the multiplier is attached combinationally through ports.

Parameters:
- W, 8, operand width; the sweep covers N = 2^(2W) pairs.
- ACC_W, 40, width of the absolute-error accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- abort  in  1  single-cycle request to stop a sweep in progress.
- op_x  out  W  operand x to the multiplier.
- op_y  out  W  operand y to the multiplier.
- approx_z  in  2W  multiplier result; combinational function of op_x and op_y, same cycle.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  high in DONE until the next accepted start.
- err_cnt  out  2W+1  number of pairs with approx_z != x*y.
- sum_abs_err  out  ACC_W  sum of |approx_z - x*y|.
- max_abs_err  out  2W  maximum of |approx_z - x*y|.
- sum_err  out  ACC_W+1  two's-complement sum of (approx_z - x*y).

Behaviour:
- Reset:
  - State goes to IDLE.
  - op_x, op_y, busy, done, err_cnt, sum_abs_err, max_abs_err and sum_err all go to 0.
  - Pipeline valid bits are cleared.
  - Reset asserted mid-sweep abandons the sweep immediately and leaves no partial results.
- States and transitions:
  - IDLE: start -> SWEEP.
  - SWEEP: last pair presented -> DRAIN; abort -> IDLE.
  - DRAIN: 2 cycles -> DONE; abort -> IDLE.
  - DONE: start -> SWEEP.
- start handling:
  - start is accepted only in IDLE or DONE.
  - On acceptance: all metrics clear to 0, op_x and op_y set to 0, done drops.
  - start while busy is ignored.
  - start and abort together in IDLE/DONE: start wins.
- Operand order in SWEEP:
  - Each cycle presents one pair.
  - op_y increments every cycle; op_x increments when op_y wraps from 2^W-1 to 0.
  - The last pair is (2^W-1, 2^W-1). After it, op_x and op_y hold their values.
- Pipeline:
  - Stage 1 registers approx_z, the exact product op_x*op_y (2W bits, unsigned) and a valid bit.
  - Stage 2 forms diff = approx_z - exact as 2W+1-bit signed and abs = |diff| as 2W bits.
  - If valid, stage 2 updates the metrics: err_cnt += (diff != 0), sum_abs_err += abs, max_abs_err = max(max_abs_err, abs), sum_err += sign-extended diff.
- Timing:
  - Start accepted at cycle 0; pairs are presented in cycles 1..N.
  - busy is high for cycles 1..N+2. done rises at cycle N+3 with all metrics final.
- Width rules: accumulators do not wrap for W <= 8 at the default ACC_W. Overflow for larger W is out of scope.
- abort:
  - State returns to IDLE and done stays 0.
  - Metrics freeze at their partial values.
  - In-flight pipeline entries are discarded (valid bits cleared).
- Outputs stay stable in IDLE and DONE; op_x and op_y are not required to be 0 there.

Decomposition:
- Package am_eval_pkg holds:
  - the state enum {IDLE, SWEEP, DRAIN, DONE};
  - localparam helpers for N, the count width 2W+1 and the diff width;
  - the DRAIN length constant (2).
- Sub-module am_err_accum holds the stage-2 logic: diff/abs formation and the four accumulators, with clear and valid inputs.
- The top level holds the FSM, the operand counters and stage 1.

Test Plan:
- Exact stub (approx_z = op_x*op_y), W=8: start at cycle 0 -> busy for cycles 1..65538, done at cycle 65539; all metrics 0.
- LSB-drop stub (approx_z = (x*y) & ~1), W=8 -> err_cnt=16384, sum_abs_err=16384, max_abs_err=1, sum_err=-16384.
- Zero stub (approx_z = 0), W=2 -> err_cnt=9, sum_abs_err=36, max_abs_err=9, sum_err=-36; done at cycle 19.
- Exact stub, W=2:
  - start again at cycle 5 -> ignored; done still at cycle 19.
  - start in DONE -> done drops next cycle, metrics clear, a new sweep runs.
- Zero stub, W=2, abort at cycle 6 -> IDLE next cycle, done=0; after a fresh start the full sweep still gives err_cnt=9.
- Zero stub, W=2, rst_n low at cycle 8 -> all outputs 0 immediately; a later start yields the same results as a clean sweep.
